data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port.
- The core is the initiator: it issues address, write data, funct3 and read/write intent; this block is the memory that serves it.
- Adds a valid/ready request/response handshake and a programmable wait-state latency so the core can be moved to a multi-cycle or stalled pipeline.
- Owns the data storage array, RV32I byte/half/word access sizing, load sign/zero extension, and error detection.

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store port between the core (master) and data memory (slave).
// Request carries access intent; response returns extended data or error.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: valid/ready load/store with wait states.
// Optional DMEM_STORE_ECHO_EN: store response returns merged word.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [31:0]   word;
  logic          f3_ok;
  logic          misal;
  logic          oor;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   merged;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_val;
  logic [31:0]   st_rdata;
  logic          commit;

  assign widx = addr_q[AW+1:2];
  assign word = mem_q[widx];

  // Access legality: funct3 per direction, alignment, range
  always_comb begin
    f3_ok = 1'b0;
    if (wr_q)
      f3_ok = f3_q inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = f3_q inside {3'b000, 3'b001, 3'b010,
                           3'b100, 3'b101};
    misal = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
            ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    oor = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
    acc_err = !f3_ok || misal || oor;
  end

  // Store lane replication, byte enables and merged word
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_q[1], 1'b0};
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
    merged = word;
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = wlane[8*b +: 8];
  end

  // Load lane select and sign/zero extension
  always_comb begin
    ld_b   = 8'(word >> {addr_q[1:0], 3'b000});
    ld_h   = addr_q[1] ? word[31:16] : word[15:0];
    ld_val = word;
    unique case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = word;
    endcase
  end

`ifdef DMEM_STORE_ECHO_EN
  assign st_rdata = merged;
`else
  assign st_rdata = '0;
`endif

  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0) &&
                  wr_q && !acc_err;

  // Storage array: never reset, written only on a legal store
  always_ff @(posedge clk) begin
    if (commit) mem_q[widx] <= merged;
  end

  // Handshake FSM next-state and captured request/response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_funct3;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          err_d   = acc_err;
          if (acc_err)   rdata_d = '0;
          else if (wr_q) rdata_d = st_rdata;
          else           rdata_d = ld_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE) & rst;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array model.
// Honors DMEM_STORE_ECHO_EN for store response expectations.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] mm [4*DEPTH];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input logic w,
                                    input logic [31:0] a,
                                    input logic [31:0] d,
                                    input logic [2:0] f,
                                    output logic [31:0] rd,
                                    output logic e);
    int sz;
    logic legal;
    logic [31:0] v, mask, base;
    if (w) legal = (f == 0) || (f == 1) || (f == 2);
    else   legal = (f == 0) || (f == 1) || (f == 2) ||
                   (f == 4) || (f == 5);
    sz = 1 << f[1:0];
    rd = 0;
    e  = !legal || ((a % sz) != 0) || ((a / 4) >= DEPTH);
    if (e) return;
    if (w) begin
      for (int i = 0; i < sz; i++) mm[a+i] = d[8*i +: 8];
`ifdef DMEM_STORE_ECHO_EN
      base = a - (a % 4);
      rd = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
`endif
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (32'(mm[a+i]) << (8*i));
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 1);
      if (!f[2] && sz < 4 && (((v >> (8*sz-1)) & 1) == 1))
        v = v | ~mask;
      rd = v;
    end
  endfunction

  task automatic xact(input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [2:0] f,
                      output logic [31:0] rd,
                      output logic er);
    logic [31:0] ed;
    logic ee;
    int lat;
    ref_model(w, a, d, f, ed, ee);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_funct3 = f;
    bus.rsp_ready  = 1'b0;
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(W + 1));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    chk("rdata", rd, ed);
    chk("err", 32'(er), 32'(ee));
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [31:0] rd, ed, a, held;
  logic er, ee, w;
  logic [2:0] f;
  int lat;

  initial begin
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.rsp_ready  = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 64; i++)
      xact(1'b1, 32'(i*4), $urandom, 3'b010, rd, er);

    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10", rd, 32'hDEADBEEF);
    xact(1'b1, 32'h11, 32'h80, 3'b000, rd, er);
    xact(1'b0, 32'h11, 32'h0, 3'b000, rd, er);
    chk("lb11", rd, 32'hFFFFFF80);
    xact(1'b0, 32'h11, 32'h0, 3'b100, rd, er);
    chk("lbu11", rd, 32'h00000080);
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10_sb", rd, 32'hDEAD80EF);
    xact(1'b0, 32'h12, 32'h0, 3'b001, rd, er);
    chk("lh12", rd, 32'hFFFFDEAD);
    xact(1'b0, 32'h12, 32'h0, 3'b101, rd, er);
    chk("lhu12", rd, 32'h0000DEAD);
    xact(1'b0, 32'h13, 32'h0, 3'b001, rd, er);
    chk("lh13_err", 32'(er), 32'd1);
    xact(1'b1, 32'h1000, 32'h12345678, 3'b010, rd, er);
    chk("sw_oor_err", 32'(er), 32'd1);
    xact(1'b0, 32'h10, 32'h0, 3'b011, rd, er);
    chk("f3_011_err", 32'(er), 32'd1);
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("lw10_keep", rd, 32'hDEAD80EF);

    ref_model(1'b0, 32'h10, 32'h0, 3'b010, ed, ee);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'b010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_lat", 32'(lat), 32'(W + 1));
    held = bus.rsp_rdata;
    chk("stall_rdata0", held, ed);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h0;
      bus.req_funct3 = 3'b010;
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rdata", bus.rsp_rdata, held);
      chk("stall_err", 32'(bus.rsp_err), 32'd0);
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("stall_drop", 32'(bus.rsp_valid), 32'd0);
    chk("stall_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("stall_noacc", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
    chk("stall_mem", rd, 32'hDEAD80EF);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h5555AAAA;
    bus.req_funct3 = 3'b010;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    chk("abort_rdata", bus.rsp_rdata, 32'd0);
    chk("abort_err", 32'(bus.rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rel", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 32'h20, 32'h0, 3'b010, rd, er);

    xact(1'b1, 32'h10, 32'h1234, 3'b001, rd, er);
`ifdef DMEM_STORE_ECHO_EN
    chk("echo_sh", rd, 32'hDEAD1234);
`else
    chk("noecho_sh", rd, 32'h0);
`endif

    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 85)
        a = 32'($urandom_range(0, 255));
      else if ($urandom_range(0, 1) == 0)
        a = 32'h1000 + 32'($urandom_range(0, 255));
      else
        a = $urandom | 32'h1000_0000;
      xact(w, a, $urandom, f, rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
